// File: rtl/counter_mod_updown.sv
`default_nettype none
// ============================================================================
// Module   : counter_mod_updown
// Purpose  : Modulo-(MAX_VALUE+1) up/down counter with enable, clamped
//            synchronous load and registered one-cycle carry/borrow pulses.
//            Define COUNTER_MOD_UPDOWN_SAT_EN for saturating instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module counter_mod_updown #(
    parameter int WIDTH     = 4,
    parameter int MAX_VALUE = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             carry_out,
    output logic             borrow_out,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] c_MAX  = MAX_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic             carry_q;
    logic             carry_d;
    logic             borrow_q;
    logic             borrow_d;

    logic             w_at_max;
    logic             w_at_min;

    assign w_at_max = (value_q == c_MAX);
    assign w_at_min = (value_q == c_ZERO);

    always_comb begin
        value_d  = value_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (load) begin
            value_d = (load_value > c_MAX) ? c_MAX : load_value;
        end else if (enable) begin
            if (up_down) begin
                // Terminal count is an explicit compare so non-power-of-2 moduli wrap correctly
                if (w_at_max) begin
                    carry_d = 1'b1;
`ifdef COUNTER_MOD_UPDOWN_SAT_EN
                    value_d = c_MAX;
`else
                    value_d = c_ZERO;
`endif
                end else begin
                    value_d = value_q + c_ONE;
                end
            end else begin
                if (w_at_min) begin
                    borrow_d = 1'b1;
`ifdef COUNTER_MOD_UPDOWN_SAT_EN
                    value_d = c_ZERO;
`else
                    value_d = c_MAX;
`endif
                end else begin
                    value_d = value_q - c_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q  <= c_ZERO;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            value_q  <= value_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign value      = value_q;
    assign carry_out  = carry_q;
    assign borrow_out = borrow_q;
    assign at_max     = w_at_max;
    assign at_min     = w_at_min;

endmodule
`default_nettype wire

// File: tb/tb_counter_mod_updown.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_mod_updown
// Purpose  : Self-checking bench; DUT A is WIDTH=4/MAX=9, DUT B is WIDTH=2/MAX=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_mod_updown;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset, a_en, a_ud, a_ld;
    logic [3:0] a_lv, a_val;
    logic       a_car, a_bor, a_amax, a_amin;

    logic       b_reset, b_en, b_ud, b_ld;
    logic [1:0] b_lv, b_val;
    logic       b_car, b_bor, b_amax, b_amin;

    counter_mod_updown #(.WIDTH(4), .MAX_VALUE(9)) dut_a (
        .clk(clk), .reset(a_reset), .enable(a_en), .up_down(a_ud), .load(a_ld),
        .load_value(a_lv), .value(a_val), .carry_out(a_car), .borrow_out(a_bor),
        .at_max(a_amax), .at_min(a_amin)
    );

    counter_mod_updown #(.WIDTH(2), .MAX_VALUE(3)) dut_b (
        .clk(clk), .reset(b_reset), .enable(b_en), .up_down(b_ud), .load(b_ld),
        .load_value(b_lv), .value(b_val), .carry_out(b_car), .borrow_out(b_bor),
        .at_max(b_amax), .at_min(b_amin)
    );

    int total = 0;
    int bad   = 0;

`ifdef COUNTER_MOD_UPDOWN_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // Reference model state
    int ma_v = 0, mb_v = 0;
    bit ma_c = 0, ma_b = 0, mb_c = 0, mb_b = 0;

    task automatic model(input int maxv, input bit rst, input bit ld, input bit en,
                         input bit ud, input int lv, inout int v, output bit c, output bit b);
        c = 1'b0;
        b = 1'b0;
        if (rst)     v = 0;
        else if (ld) v = (lv > maxv) ? maxv : lv;
        else if (en) begin
            if (ud) begin
                c = (v == maxv);
                if (!(SAT && c)) v = (v + 1) % (maxv + 1);
            end else begin
                b = (v == 0);
                if (!(SAT && b)) v = (v + maxv) % (maxv + 1);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model(9, a_reset, a_ld, a_en, a_ud, int'(a_lv), ma_v, ma_c, ma_b);
        model(3, b_reset, b_ld, b_en, b_ud, int'(b_lv), mb_v, mb_c, mb_b);
        #1;
    endtask

    task automatic idle_all();
        a_reset = 0; a_en = 0; a_ud = 0; a_ld = 0; a_lv = '0;
        b_reset = 0; b_en = 0; b_ud = 0; b_ld = 0; b_lv = '0;
    endtask

    task automatic test_reset();
        idle_all();
        a_reset = 1; b_reset = 1; a_en = 1; b_en = 1; a_ud = 1; b_ud = 1;
        tick();
        total++;
        if ({a_val, a_car, a_bor, a_amax, a_amin} !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_a: got val=%0d c=%b b=%b max=%b min=%b, want 0 0 0 0 1",
                     a_val, a_car, a_bor, a_amax, a_amin);
        end
        total++;
        if ({b_val, b_car, b_bor, b_amax, b_amin} !== {2'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_b: got val=%0d c=%b b=%b max=%b min=%b, want 0 0 0 0 1",
                     b_val, b_car, b_bor, b_amax, b_amin);
        end
        idle_all();
    endtask

    task automatic test_wrap_w2();
        int exp_v[5] = '{1, 2, 3, 0, 1};
        b_en = 1; b_ud = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({b_val, b_car, b_amax, b_amin} !==
                {2'(exp_v[i]), exp_v[i] == 0, exp_v[i] == 3, exp_v[i] == 0}) begin
                bad++;
                $display("FAIL wrap_w2[%0d]: got val=%0d c=%b max=%b min=%b, want val=%0d c=%b",
                         i, b_val, b_car, b_amax, b_amin, exp_v[i], exp_v[i] == 0);
            end
        end
        idle_all();
    endtask

    task automatic test_up_mod10();
        a_en = 1; a_ud = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if ({a_val, a_car, a_bor, a_amax, a_amin} !==
                {4'(ma_v), ma_c, ma_b, ma_v == 9, ma_v == 0} || a_val !== 4'((i + 1) % 10)) begin
                bad++;
                $display("FAIL up_mod10[%0d]: got val=%0d c=%b b=%b max=%b, want val=%0d c=%b",
                         i, a_val, a_car, a_bor, a_amax, (i + 1) % 10, ma_c);
            end
        end
        idle_all();
    endtask

    task automatic test_load_clamp_down();
        a_ld = 1; a_lv = 4'd12; a_en = 1; a_ud = 1;
        tick();
        total++;
        if ({a_val, a_car, a_bor, a_amax} !== {4'd9, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL load_clamp: got val=%0d c=%b b=%b max=%b, want 9 0 0 1",
                     a_val, a_car, a_bor, a_amax);
        end
        idle_all();
        a_en = 1; a_ud = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({a_val, a_car, a_bor, a_amax, a_amin} !==
                {4'(ma_v), ma_c, ma_b, ma_v == 9, ma_v == 0} || a_bor !== (i == 9)) begin
                bad++;
                $display("FAIL down_mod10[%0d]: got val=%0d b=%b min=%b, want val=%0d b=%b",
                         i, a_val, a_bor, a_amin, ma_v, ma_b);
            end
        end
        idle_all();
    endtask

    task automatic test_load_priority();
        a_ld = 1; a_lv = 4'd7;
        tick();
        a_ld = 1; a_lv = 4'd5; a_en = 1; a_ud = 1;
        tick();
        total++;
        if ({a_val, a_car, a_bor} !== {4'd5, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL load_priority: got val=%0d c=%b b=%b, want 5 0 0", a_val, a_car, a_bor);
        end
        idle_all();
        for (int i = 0; i < 3; i++) begin
            a_ud = 1'($urandom_range(0, 1));
            tick();
            total++;
            if ({a_val, a_car, a_bor} !== {4'd5, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL hold[%0d]: got val=%0d c=%b b=%b, want 5 0 0", i, a_val, a_car, a_bor);
            end
        end
        idle_all();
    endtask

    task automatic test_reset_override();
        b_ld = 1; b_lv = 2'd3;
        tick();
        b_ld = 0; b_en = 1; b_ud = 1; b_reset = 1;
        tick();
        total++;
        if ({b_val, b_car, b_bor, b_amin} !== {2'd0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_override: got val=%0d c=%b b=%b, want 0 0 0", b_val, b_car, b_bor);
        end
        b_reset = 0;
        tick();
        total++;
        if ({b_val, b_car} !== {2'd1, 1'b0}) begin
            bad++;
            $display("FAIL resume: got val=%0d c=%b, want 1 0", b_val, b_car);
        end
        idle_all();
    endtask

    task automatic test_saturation_edge();
        a_ld = 1; a_lv = 4'd8;
        tick();
        a_ld = 0; a_en = 1; a_ud = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({a_val, a_car, a_bor, a_amax} !== {4'(ma_v), ma_c, ma_b, ma_v == 9}) begin
                bad++;
                $display("FAIL top_edge[%0d]: got val=%0d c=%b, want val=%0d c=%b",
                         i, a_val, a_car, ma_v, ma_c);
            end
        end
        a_ld = 1; a_lv = 4'd1; a_en = 0;
        tick();
        a_ld = 0; a_en = 1; a_ud = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({a_val, a_car, a_bor, a_amin} !== {4'(ma_v), ma_c, ma_b, ma_v == 0}) begin
                bad++;
                $display("FAIL bottom_edge[%0d]: got val=%0d b=%b, want val=%0d b=%b",
                         i, a_val, a_bor, ma_v, ma_b);
            end
        end
        idle_all();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            a_reset = ($urandom_range(0, 49) == 0);
            a_ld    = ($urandom_range(0, 9) == 0);
            a_en    = ($urandom_range(0, 3) != 0);
            a_ud    = 1'($urandom_range(0, 1));
            a_lv    = 4'($urandom_range(0, 15));
            b_reset = ($urandom_range(0, 49) == 0);
            b_ld    = ($urandom_range(0, 9) == 0);
            b_en    = ($urandom_range(0, 3) != 0);
            b_ud    = 1'($urandom_range(0, 1));
            b_lv    = 2'($urandom_range(0, 3));
            tick();
            total++;
            if ({a_val, a_car, a_bor, a_amax, a_amin} !==
                {4'(ma_v), ma_c, ma_b, ma_v == 9, ma_v == 0}) begin
                bad++;
                $display("FAIL random_a[%0d]: got val=%0d c=%b b=%b max=%b min=%b, want val=%0d c=%b b=%b",
                         i, a_val, a_car, a_bor, a_amax, a_amin, ma_v, ma_c, ma_b);
            end
            total++;
            if ({b_val, b_car, b_bor, b_amax, b_amin} !==
                {2'(mb_v), mb_c, mb_b, mb_v == 3, mb_v == 0}) begin
                bad++;
                $display("FAIL random_b[%0d]: got val=%0d c=%b b=%b max=%b min=%b, want val=%0d c=%b b=%b",
                         i, b_val, b_car, b_bor, b_amax, b_amin, mb_v, mb_c, mb_b);
            end
        end
        idle_all();
    endtask

    initial begin
        idle_all();
        test_reset();
        test_wrap_w2();
        test_reset();
        test_up_mod10();
        test_load_clamp_down();
        test_load_priority();
        test_reset_override();
        test_saturation_edge();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_mod_updown.md
Name: counter_mod_updown

Overview:
- Parametrised successor to the fixed 2-bit binary counter.
- Modulo-N up/down counter with count enable, synchronous parallel load, and registered one-cycle carry/borrow pulses.
- Used as a building block for prescalers, cascaded timers and address sequencers. Carry/borrow of one stage drives the enable of the next stage.

Parameters:
- WIDTH, 4, counter width in bits (>=1).
- MAX_VALUE, 2**WIDTH-1, terminal count. Counter runs 0..MAX_VALUE, so modulus = MAX_VALUE+1. Must satisfy 1 <= MAX_VALUE <= 2**WIDTH-1.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count enable; counts only when high.
- up_down  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load strobe.
- load_value  input  WIDTH  value written on load.
- value  output  WIDTH  current count (registered).
- carry_out  output  1  registered one-cycle pulse on up-wrap.
- borrow_out  output  1  registered one-cycle pulse on down-wrap.
- at_max  output  1  combinational, value == MAX_VALUE.
- at_min  output  1  combinational, value == 0.

Behaviour:
- Interface: one clock clk. Reset is synchronous and active-high, on port reset, sampled on the rising edge of clk. No asynchronous paths.
- All state updates on the rising edge of clk. Priority order: reset > load > enable > hold.
- Reset: next cycle value=0, carry_out=0, borrow_out=0. at_min=1 and at_max=0 follow combinationally (at_max=1 only if MAX_VALUE==0, which is illegal).
- Load (reset=0, load=1):
  - value <= load_value if load_value <= MAX_VALUE, else value <= MAX_VALUE (clamp).
  - carry_out and borrow_out <= 0.
  - enable and up_down are ignored that cycle.
- Count up (enable=1, up_down=1):
  - If value < MAX_VALUE: value+1, carry_out <= 0.
  - If value == MAX_VALUE: value <= 0, carry_out <= 1.
- Count down (enable=1, up_down=0):
  - If value > 0: value-1, borrow_out <= 0.
  - If value == 0: value <= MAX_VALUE, borrow_out <= 1.
- Hold (enable=0): value unchanged; carry_out and borrow_out <= 0.
- Pulse timing:
  - carry_out/borrow_out are high for exactly the one cycle in which value shows the wrapped result.
  - They are never both high.
  - Consecutive wraps (MAX_VALUE reached again while counting) give separate pulses.
- Direction may change on any cycle. The new direction applies to that edge.
- Reset mid-count overrides everything, including a pending wrap: carry/borrow are 0 after reset.
- Arithmetic stays within WIDTH bits. The non-power-of-2 wrap is an explicit compare, never natural overflow.

Optional Feature:
- Macro: COUNTER_MOD_UPDOWN_SAT_EN.
- Defined (saturating mode):
  - Counting up at MAX_VALUE holds at MAX_VALUE; counting down at 0 holds at 0.
  - carry_out (resp. borrow_out) still pulses for each cycle an overflow (resp. underflow) is attempted, flagging the saturation event.
- Undefined: wrap behaviour as above.
- Load clamp, reset and all other behaviour are identical in both builds.

Test Plan:
- WIDTH=2, MAX_VALUE=3, reset then enable=1, up_down=1 for 5 cycles -> value 1,2,3,0,1. carry_out=1 only in the cycle value=0.
- WIDTH=4, MAX_VALUE=9, count up from 0 for 12 cycles -> value 1..9,0,1,2. carry_out pulses once with value=0. at_max=1 while value=9.
- WIDTH=4, MAX_VALUE=9, load=1 with load_value=12 -> value=9 next cycle. Then down-count 10 cycles -> 8..0,9. borrow_out pulses once with value=9.
- load=1 and enable=1 same cycle with load_value=5, value=7 -> value=5, no carry/borrow. Then enable=0 for 3 cycles -> value stays 5.
- At value=3 (MAX_VALUE=3) with enable=1, up_down=1, assert reset -> value=0, carry_out=0 next cycle. Resume counting -> value=1.
- With COUNTER_MOD_UPDOWN_SAT_EN, MAX_VALUE=9, count up from 8 for 4 cycles -> value 9,9,9,9. carry_out=0,1,1,1.
